// File: rtl/imm_encoder_pkg.sv
// ---------------------------------------------------------------------------
// imm_encoder_pkg
//   Shared definitions for the instruction encoder and the core's immediate
//   extender: the instruction-format code and the immediate width of each
//   format. Also holds a helper that tests whether a value fits a signed
//   field of a given width.
// ---------------------------------------------------------------------------
package imm_encoder_pkg;

    // Instruction format selected by ImmSrc. Codes 5-7 are unused and are
    // treated as out-of-range requests by the encoder.
    typedef enum logic [2:0] {
        IMM     = 3'd0,
        STORE   = 3'd1,
        BRANCH  = 3'd2,
        JUMP    = 3'd3,
        UPP_IMM = 3'd4
    } instr_type_e;

    // Immediate field width per format, in bits, counted from the LSB of the
    // byte offset (B and J include the implicit zero LSB).
    localparam int unsigned IMM_I_BITS = 12;
    localparam int unsigned IMM_S_BITS = 12;
    localparam int unsigned IMM_B_BITS = 13;
    localparam int unsigned IMM_J_BITS = 21;
    localparam int unsigned IMM_U_BITS = 20;

    // True when value is a sign extension of its low 'bits' bits, i.e.
    // value[31:bits-1] are all equal.
    function automatic logic fits_signed(input logic [31:0] value,
                                         input int unsigned bits);
        logic [31:0] upper;
        upper = $signed(value) >>> (bits - 1);
        return (upper == '0) || (upper == '1);
    endfunction

endpackage

// File: rtl/imm_encoder_range_check.sv
// ---------------------------------------------------------------------------
// imm_range_check
//   Combinational range check of a byte-offset immediate against the format
//   it will be packed into.
//   i_imm_src : format code (instr_type_e values, 5-7 unused)
//   i_imm     : signed immediate
//   o_err     : 1 when the immediate cannot be represented exactly
// ---------------------------------------------------------------------------
module imm_range_check
    import imm_encoder_pkg::*;
(
    input  logic [2:0]  i_imm_src,
    input  logic [31:0] i_imm,
    output logic        o_err
);

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        o_err = 1'b1;
        case (i_imm_src)
            IMM:     o_err = !fits_signed(i_imm, IMM_I_BITS);
            STORE:   o_err = !fits_signed(i_imm, IMM_S_BITS);
            BRANCH:  o_err = !fits_signed(i_imm, IMM_B_BITS) || i_imm[0];
            JUMP:    o_err = !fits_signed(i_imm, IMM_J_BITS) || i_imm[0];
            // The U-type field holds bits [31:12]; the low 12 must be zero.
            UPP_IMM: o_err = (i_imm[31-IMM_U_BITS:0] != '0);
            default: o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// ---------------------------------------------------------------------------
// imm_encoder
//   Two-stage pipelined RISC-V instruction encoder with valid/ready flow
//   control. S1 registers the request and its range-check result; S2 packs
//   the fields into the output register. Saturating counters tally emitted
//   words with and without the error flag.
//   clk, rst_n              : clock, async active-low reset
//   in_valid / in_ready     : request handshake
//   in_ImmSrc               : format code (instr_type_e)
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm : request fields
//   out_valid / out_ready   : result handshake
//   out_instr, out_err      : packed word and its out-of-range flag
//   cnt_ok, cnt_err         : saturating counts of emitted words
// ---------------------------------------------------------------------------
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_ImmSrc,
    input  logic [6:0]             in_opcode,
    input  logic [4:0]             in_rd,
    input  logic [4:0]             in_rs1,
    input  logic [4:0]             in_rs2,
    input  logic [2:0]             in_funct3,
    input  logic [31:0]            in_imm,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic                   out_err,
    output logic [CNT_WIDTH-1:0]   cnt_ok,
    output logic [CNT_WIDTH-1:0]   cnt_err
);

    // S1 state
    logic        r_s1_valid;
    logic [2:0]  r_s1_src;
    logic [6:0]  r_s1_opcode;
    logic [4:0]  r_s1_rd;
    logic [4:0]  r_s1_rs1;
    logic [4:0]  r_s1_rs2;
    logic [2:0]  r_s1_funct3;
    logic [31:0] r_s1_imm;
    logic        r_s1_err;

    // S2 / output state
    logic                   r_out_valid;
    logic [INSTR_WIDTH-1:0] r_out_instr;
    logic                   r_out_err;
    logic [CNT_WIDTH-1:0]   r_cnt_ok;
    logic [CNT_WIDTH-1:0]   r_cnt_err;

    logic        w_s2_adv;
    logic        w_s1_adv;
    logic        w_in_err;
    logic [31:0] w_packed;

    // S2 moves when its word is gone or leaving; S1 moves when empty or S2
    // takes its word. in_ready therefore follows out_ready combinationally,
    // which lets a full pipeline keep streaming without a bubble.
    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    imm_range_check u_range_check (
        .i_imm_src (in_ImmSrc),
        .i_imm     (in_imm),
        .o_err     (w_in_err)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
        end
    end

    // NOTE: the S1 payload is not reset; r_s1_valid qualifies it, so a
    // reset value would never be observed.
    always_ff @(posedge clk) begin
        if (w_s1_adv && in_valid) begin
            r_s1_src    <= in_ImmSrc;
            r_s1_opcode <= in_opcode;
            r_s1_rd     <= in_rd;
            r_s1_rs1    <= in_rs1;
            r_s1_rs2    <= in_rs2;
            r_s1_funct3 <= in_funct3;
            r_s1_imm    <= in_imm;
            r_s1_err    <= w_in_err;
        end
    end

    // Field packing; an out-of-range immediate is truncated by the same bit
    // selection. Unused codes pack as I-type.
    always_comb begin
        w_packed = {r_s1_imm[11:0], r_s1_rs1, r_s1_funct3, r_s1_rd, r_s1_opcode};
        case (r_s1_src)
            STORE:   w_packed = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_funct3,
                                 r_s1_imm[4:0], r_s1_opcode};
            BRANCH:  w_packed = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1,
                                 r_s1_funct3, r_s1_imm[4:1], r_s1_imm[11], r_s1_opcode};
            JUMP:    w_packed = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11],
                                 r_s1_imm[19:12], r_s1_rd, r_s1_opcode};
            UPP_IMM: w_packed = {r_s1_imm[31:12], r_s1_rd, r_s1_opcode};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_err   <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            // Hold the last word when no new one arrives.
            if (r_s1_valid) begin
                r_out_instr <= w_packed;
                r_out_err   <= r_s1_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_ok  <= '0;
            r_cnt_err <= '0;
        end else if (r_out_valid && out_ready) begin
            if (r_out_err) begin
                if (r_cnt_err != '1) r_cnt_err <= r_cnt_err + 1'b1;
            end else begin
                if (r_cnt_ok != '1) r_cnt_ok <= r_cnt_ok + 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_err   = r_out_err;
    assign cnt_ok    = r_cnt_ok;
    assign cnt_err   = r_cnt_err;

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Pipelined RISC-V instruction encoder: accepts an instruction-format code, register/funct fields and a 32-bit signed immediate, then emits the packed 32-bit instruction word. It sits in the program-loader/test-generator path in front of instruction memory and is the inverse of the core's immediate extraction. It range-checks every immediate, applies valid/ready backpressure, and keeps saturating success/error counters.

## Interface
- INSTR_WIDTH, 32, instruction word width; only 32 is supported.
- CNT_WIDTH, 16, width of the statistics counters.

- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  request valid.
- in_ready  output  1  encoder can accept a request this cycle.
- in_ImmSrc  input  3  format code: Imm=0, Store=1, Branch=2, Jump=3, UppImm=4.
- in_opcode  input  7  opcode field.
- in_rd, in_rs1, in_rs2  input  5 each  register fields.
- in_funct3  input  3  funct3 field.
- in_imm  input  32  signed byte-offset immediate.
- out_valid  output  1  encoded word valid.
- out_ready  input  1  consumer accepts the word.
- out_instr  output  INSTR_WIDTH  packed instruction word.
- out_err  output  1  immediate not representable; travels with out_instr.
- cnt_ok, cnt_err  output  CNT_WIDTH each  words emitted with out_err=0 / out_err=1.

## Operation
- Two-stage pipeline:
  - S1 registers the request and computes err.
  - S2 packs the fields and holds the output register.
- Range rules (err=1 when violated):
  - Imm, Store: in_imm[31:11] all equal.
  - Branch: in_imm[31:12] all equal and in_imm[0]=0.
  - Jump: in_imm[31:20] all equal and in_imm[0]=0.
  - UppImm: in_imm[11:0]=0.
  - ImmSrc 5–7: always err=1; the word is packed as Imm.
- Packing, MSB→LSB:
  - Imm: imm[11:0], rs1, funct3, rd, opcode.
  - Store: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
  - Branch: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
  - Jump: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
  - UppImm: imm[31:12], rd, opcode.
- On err, the word is still emitted, with the immediate truncated by the same bit selection.
- Fields the format does not use are ignored.
- Counters:
  - Each output handshake (out_valid & out_ready) increments cnt_err if out_err=1, otherwise cnt_ok.
  - Both counters saturate at all-ones.

## Timing
- Request accepted on in_valid & in_ready.
- The word appears on out_valid/out_instr exactly 2 cycles after acceptance when there is no backpressure.
- Throughput: 1 word per cycle.
- S2 advances when !out_valid | out_ready.
- S1 advances when !s1_valid | S2 advances.
- in_ready = !s1_valid | S2 advances. This is a combinational path from out_ready, with no bubble.
- While out_valid=1 and out_ready=0:
  - out_instr and out_err are held stable.
  - With S1 full, in_ready=0.
- When a request is accepted in the same cycle S1 hands off to S2, S1 reloads with no lost or duplicated word.
- Reset values: out_valid=0, out_instr=0, out_err=0, cnt_ok=0, cnt_err=0, S1 valid=0. in_ready=1 out of reset.
- Reset mid-operation drops all in-flight words immediately; counters clear.

## Structure
- Shared package holds:
  - the Instr_type enum (Imm, Store, Branch, Jump, UppImm; 3 bits);
  - the per-format immediate bit-count constants.
- The core's immediate extender uses the same package.
- One sub-module, imm_range_check: combinational; takes ImmSrc and imm, outputs err. It is instantiated in S1.
- Field packing is a case statement in the S2 next-state logic.

## Test plan
- Imm, opcode=0x13, rd=1, rs1=2, funct3=0, imm=-1 → out_instr=0xFFF10093, err=0, valid 2 cycles after accept.
- Branch, opcode=0x63, rs1=1, rs2=2, imm=-4 → 0xFE208EE3, err=0. Branch with imm=0x1000 → err=1, cnt_err=1.
- Jump imm=3 → err=1 (misaligned). UppImm imm=0x12345000, rd=5, opcode=0x37 → 0x123452B7, err=0.
- Back-to-back stream of 8 requests with out_ready toggling 1/0 → all 8 words in order, no drops or duplicates, out_instr stable while stalled, in_ready low only while both stages are full.
- Round trip: 1000 random in-range requests → re-extending each out_instr with the ImmSrc decode rules returns in_imm; cnt_ok=1000. Also force cnt_ok to saturation and confirm it holds.
- Assert rst_n low with 2 words in flight → out_valid and counters are 0 asynchronously; the first post-reset request emerges after 2 cycles.
